// File: rtl/cohort_mem_req_arbiter.sv
// cohort_mem_req_arbiter
//   Shares one 64-bit memory request port between NUM_REQ accelerator
//   requesters. Round-robin grant with a HOLD state that locks the presented
//   requester until the downstream port accepts. A tag FIFO records
//   {requester, type} for every accepted request. Responses come back in
//   request order and are routed to the originating requester.
//
//   Transaction type encoding: 0 = load, 1 = store.
//
//   Ports
//     clk_i, rst_ni                       clock, async active-low reset
//     req_valid_i/req_ready_o             per-requester request handshake
//     req_type_i/addr_i/size_i/data_i     per-requester payload, req0 at LSBs
//     mem_req_*                           downstream request channel
//     mem_rsp_valid_i/ready_o/data_i      downstream response channel
//     rsp_valid_o/ready_i                 one-hot response to originator
//     rsp_data_o, rsp_type_o              broadcast response payload
//     busy_o                              requests in flight
//     err_o                               sticky: response with nothing in flight
//     grant_cnt_o                         per-requester 32-bit grant counters
//
//   Optional feature: define COHORT_ARB_PERF_CNT_EN to build the saturating
//   grant counters; otherwise grant_cnt_o is tied to zero.
//
//   state | meaning
//   ARB   | no pending grant; pick next valid requester round-robin
//   HOLD  | grant presented but not accepted; locked to lock_q

module cohort_mem_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic [NUM_REQ-1:0]    req_type_i,
   input  logic [NUM_REQ*40-1:0] req_addr_i,
   input  logic [NUM_REQ*3-1:0]  req_size_i,
   input  logic [NUM_REQ*64-1:0] req_data_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic                  mem_req_type_o,
   output logic [39:0]           mem_req_addr_o,
   output logic [2:0]            mem_req_size_o,
   output logic [63:0]           mem_req_data_o,
   input  logic                  mem_rsp_valid_i,
   output logic                  mem_rsp_ready_o,
   input  logic [63:0]           mem_rsp_data_i,
   output logic [NUM_REQ-1:0]    rsp_valid_o,
   input  logic [NUM_REQ-1:0]    rsp_ready_i,
   output logic [63:0]           rsp_data_o,
   output logic                  rsp_type_o,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [NUM_REQ*32-1:0] grant_cnt_o
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CAND_W = IDX_W + 1;
   localparam int PTR_W  = $clog2(OUTSTANDING);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic {ST_ARB, ST_HOLD} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    lock_q, lock_d;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q;
   logic                err_q;
   logic [IDX_W:0]      tag_q [OUTSTANDING];

   logic [IDX_W-1:0]    sel_idx, grant_idx, head_idx;
   logic [CAND_W-1:0]   cand;
   logic                found, mem_req_valid, handshake;
   logic                fifo_empty, head_type, pop;

   // Round-robin pick: first valid index at or after rr_ptr_q, wrapping.
   always_comb begin
      sel_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + CAND_W'(k);
         if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
         if (!found && req_valid_i[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            sel_idx = cand[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      lock_d        = lock_q;
      grant_idx     = sel_idx;
      mem_req_valid = 1'b0;
      case (state_q)
         ST_ARB: begin
            // Full gating uses the registered count, so a same-cycle pop never frees a slot.
            mem_req_valid = found && (count_q < CNT_W'(OUTSTANDING));
            if (mem_req_valid && !mem_req_ready_i) begin
               state_d = ST_HOLD;
               lock_d  = sel_idx;
            end
         end
         ST_HOLD: begin
            grant_idx     = lock_q;
            mem_req_valid = 1'b1;
            if (mem_req_ready_i) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
   end

   assign handshake       = mem_req_valid && mem_req_ready_i;
   assign mem_req_valid_o = mem_req_valid;
   assign mem_req_type_o  = mem_req_valid ? req_type_i[grant_idx] : 1'b0;
   assign mem_req_addr_o  = mem_req_valid ? req_addr_i[grant_idx*40 +: 40] : '0;
   assign mem_req_size_o  = mem_req_valid ? req_size_i[grant_idx*3 +: 3] : '0;
   assign mem_req_data_o  = mem_req_valid ? req_data_i[grant_idx*64 +: 64] : '0;
   assign req_ready_o     = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

   assign fifo_empty = (count_q == '0);
   assign head_idx   = tag_q[rd_ptr_q][IDX_W:1];
   assign head_type  = tag_q[rd_ptr_q][0];

   // With nothing in flight a response is accepted and dropped.
   always_comb begin
      rsp_valid_o     = '0;
      mem_rsp_ready_o = mem_rsp_valid_i;
      if (!fifo_empty) begin
         rsp_valid_o[head_idx] = mem_rsp_valid_i;
         mem_rsp_ready_o       = rsp_ready_i[head_idx];
      end
   end

   assign pop        = mem_rsp_valid_i && mem_rsp_ready_o && !fifo_empty;
   assign rsp_data_o = mem_rsp_data_i;
   assign rsp_type_o = fifo_empty ? 1'b0 : head_type;
   assign busy_o     = !fifo_empty;
   assign err_o      = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_ARB;
         lock_q   <= '0;
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         if (handshake) begin
            rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({handshake, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (mem_rsp_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (handshake) tag_q[wr_ptr_q] <= {grant_idx, req_type_i[grant_idx]};
   end

`ifdef COHORT_ARB_PERF_CNT_EN
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      logic [31:0] cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) cnt_q <= '0;
         else if (handshake && grant_idx == IDX_W'(g) && cnt_q != 32'hFFFF_FFFF)
            cnt_q <= cnt_q + 32'd1;
      end
      assign grant_cnt_o[g*32 +: 32] = cnt_q;
   end
`else
   assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cohort_mem_req_arbiter.sv
// Self-checking bench for cohort_mem_req_arbiter: directed scenarios followed
// by a randomized run, all compared against a queue-based reference model.
module tb_cohort_mem_req_arbiter;
   localparam int N   = 4;
   localparam int OUT = 4;
   localparam logic T_LOAD  = 1'b0;
   localparam logic T_STORE = 1'b1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, req_type;
   logic [N*40-1:0] req_addr;
   logic [N*3-1:0]  req_size;
   logic [N*64-1:0] req_data;
   logic            mem_req_valid, mem_req_ready, mem_req_type;
   logic [39:0]     mem_req_addr;
   logic [2:0]      mem_req_size;
   logic [63:0]     mem_req_data;
   logic            mem_rsp_valid, mem_rsp_ready;
   logic [63:0]     mem_rsp_data;
   logic [N-1:0]    rsp_valid, rsp_ready;
   logic [63:0]     rsp_data;
   logic            rsp_type, busy, err;
   logic [N*32-1:0] grant_cnt;

   cohort_mem_req_arbiter #(.NUM_REQ(N), .OUTSTANDING(OUT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_type_i(req_type),
      .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
      .mem_req_type_o(mem_req_type), .mem_req_addr_o(mem_req_addr),
      .mem_req_size_o(mem_req_size), .mem_req_data_o(mem_req_data),
      .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_ready_o(mem_rsp_ready),
      .mem_rsp_data_i(mem_rsp_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_type_o(rsp_type),
      .busy_o(busy), .err_o(err), .grant_cnt_o(grant_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: in-flight queue, rotating priority, pending lock.
   typedef struct {int idx; logic typ;} tag_t;
   tag_t        q[$];
   int          rr, locked;
   logic        m_err;
   int unsigned m_cnt[N];

   // Per-cycle model decisions, consumed by tick()
   int   e_gi, hs_idx;
   logic e_valid, e_hs, e_rready;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic t, input logic [39:0] a,
                          input logic [2:0] s, input logic [63:0] d);
      req_type[i]          = t;
      req_addr[i*40 +: 40] = a;
      req_size[i*3 +: 3]   = s;
      req_data[i*64 +: 64] = d;
      req_valid[i]         = 1'b1;
   endtask

   task automatic zero_inputs();
      req_valid = '0; req_type = '0; req_addr = '0; req_size = '0; req_data = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; rsp_ready = '0;
   endtask

   task automatic model_reset();
      q.delete();
      rr = 0; locked = -1; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
      check({tag, "_mem_req_addr"}, 64'(mem_req_addr), 64'd0);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_mem_rsp_ready"}, 64'(mem_rsp_ready), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_grant_cnt"}, 64'(grant_cnt[63:0]), 64'd0);
   endtask

   // Full reset, ends 1 time unit after a rising edge with inputs idle.
   task automatic do_reset(input string tag);
      zero_inputs();
      rst_n = 1'b0;
      #2;
      check_reset_outputs(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Compare all outputs against the model for the current inputs.
   task automatic eval();
      logic [N-1:0] exp_rv;
      tag_t h;
      #1;
      e_gi = -1;
      if (locked >= 0) begin
         e_gi    = locked;
         e_valid = 1'b1;
      end else begin
         e_valid = (req_valid != '0) && (q.size() < OUT);
         if (e_valid)
            for (int k = 0; k < N; k++)
               if (e_gi < 0 && req_valid[(rr + k) % N]) e_gi = (rr + k) % N;
      end
      e_hs = e_valid && mem_req_ready;
      check("mem_req_valid", 64'(mem_req_valid), 64'(e_valid));
      if (e_valid) begin
         check("mem_req_type", 64'(mem_req_type), 64'(req_type[e_gi]));
         check("mem_req_addr", 64'(mem_req_addr), 64'(req_addr[e_gi*40 +: 40]));
         check("mem_req_size", 64'(mem_req_size), 64'(req_size[e_gi*3 +: 3]));
         check("mem_req_data", mem_req_data, req_data[e_gi*64 +: 64]);
      end
      check("req_ready", 64'(req_ready), e_hs ? (64'd1 << e_gi) : 64'd0);
      exp_rv = '0;
      if (q.size() == 0) begin
         e_rready = mem_rsp_valid;
      end else begin
         h = q[0];
         exp_rv[h.idx] = mem_rsp_valid;
         e_rready = rsp_ready[h.idx];
         if (mem_rsp_valid) begin
            check("rsp_type", 64'(rsp_type), 64'(h.typ));
            check("rsp_data", rsp_data, mem_rsp_data);
         end
      end
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("mem_rsp_ready", 64'(mem_rsp_ready), 64'(e_rready));
      check("busy", 64'(busy), 64'(q.size() != 0));
      check("err", 64'(err), 64'(m_err));
      for (int i = 0; i < N; i++) begin
`ifdef COHORT_ARB_PERF_CNT_EN
         check("grant_cnt", 64'(grant_cnt[i*32 +: 32]), 64'(m_cnt[i]));
`else
         check("grant_cnt", 64'(grant_cnt[i*32 +: 32]), 64'd0);
`endif
      end
   endtask

   // Clock edge; update the model with this cycle's decisions.
   task automatic tick();
      logic do_pop;
      do_pop = 1'b0;
      if (mem_rsp_valid) begin
         if (q.size() == 0) m_err = 1'b1;
         else if (e_rready) do_pop = 1'b1;
      end
      hs_idx = -1;
      @(posedge clk);
      if (e_hs) begin
         q.push_back('{idx: e_gi, typ: req_type[e_gi]});
         rr     = (e_gi + 1) % N;
         locked = -1;
         hs_idx = e_gi;
         if (m_cnt[e_gi] != 32'hFFFF_FFFF) m_cnt[e_gi]++;
      end else if (e_valid) begin
         locked = e_gi;
      end
      if (do_pop) void'(q.pop_front());
      #1;
   endtask

   task automatic cycle();
      eval();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      zero_inputs();
      model_reset();

      // Reset values
      do_reset("reset");

      // Single load from requester 0
      set_req(0, T_LOAD, 40'h80_0000_1000, 3'd3, 64'h1111_2222_3333_4444);
      mem_req_ready = 1'b1;
      eval();
      check("single_addr", 64'(mem_req_addr), 64'h80_0000_1000);
      tick();
      req_valid = '0;
      check("single_busy", 64'(busy), 64'd1);
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD_BEEF_0123_4567; rsp_ready = 4'b0001;
      eval();
      check("single_rsp_valid", 64'(rsp_valid), 64'b0001);
      check("single_rsp_type", 64'(rsp_type), 64'(T_LOAD));
      tick();
      mem_rsp_valid = 1'b0;
      check("single_busy_clr", 64'(busy), 64'd0);

      // Round robin with a steady drain
      do_reset("rr_reset");
      for (int i = 0; i < N; i++)
         set_req(i, 1'(i & 1), 40'(64'h10_0000_0000 + i * 64), 3'(i), 64'(i) * 64'h0101);
      mem_req_ready = 1'b1;
      rsp_ready = '1;
      for (int k = 0; k < 8; k++) begin
         mem_rsp_valid = (q.size() != 0);
         mem_rsp_data  = 64'(k);
         eval();
         check("rr_order", 64'(onehot_idx(req_ready)), 64'(k % N));
         tick();
      end
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
`ifdef COHORT_ARB_PERF_CNT_EN
         check("rr_grant_cnt", 64'(grant_cnt[i*32 +: 32]), 64'd2);
`else
         check("rr_grant_cnt", 64'(grant_cnt[i*32 +: 32]), 64'd0);
`endif
      end

      // HOLD stability
      do_reset("hold_reset");
      set_req(2, T_STORE, 40'h22_2222_2222, 3'd2, 64'hAAAA);
      mem_req_ready = 1'b0;
      cycle();
      set_req(1, T_LOAD, 40'h11_1111_1111, 3'd1, 64'hBBBB);
      for (int k = 0; k < 3; k++) begin
         eval();
         check("hold_addr", 64'(mem_req_addr), 64'h22_2222_2222);
         check("hold_req_ready", 64'(req_ready), 64'd0);
         tick();
      end
      set_req(3, T_LOAD, 40'h33_3333_3333, 3'd0, 64'hCCCC);
      mem_req_ready = 1'b1;
      eval();
      check("hold_accept", 64'(onehot_idx(req_ready)), 64'd2);
      tick();
      req_valid[2] = 1'b0;
      eval();
      check("hold_next3", 64'(onehot_idx(req_ready)), 64'd3);
      tick();
      req_valid[3] = 1'b0;
      eval();
      check("hold_next1", 64'(onehot_idx(req_ready)), 64'd1);
      tick();
      req_valid[1] = 1'b0;

      // Full and same-cycle pop
      do_reset("full_reset");
      for (int i = 0; i < N; i++) set_req(i, T_LOAD, 40'(i + 5), 3'd3, 64'(i));
      mem_req_ready = 1'b1;
      for (int k = 0; k < OUT; k++) cycle();
      eval();
      check("full_valid", 64'(mem_req_valid), 64'd0);
      tick();
      mem_rsp_valid = 1'b1; rsp_ready = '1; mem_rsp_data = 64'h5A5A;
      eval();
      check("full_pop_no_push", 64'(req_ready), 64'd0);
      tick();
      mem_rsp_valid = 1'b0;
      eval();
      check("full_push_next", 64'(req_ready != '0), 64'd1);
      tick();
      req_valid = '0;
      cycle();

      // Out-of-turn back-pressure
      do_reset("bp_reset");
      set_req(1, T_LOAD, 40'h1, 3'd3, 64'h1);
      mem_req_ready = 1'b1;
      cycle();
      req_valid = '0;
      set_req(3, T_STORE, 40'h3, 3'd3, 64'h3);
      cycle();
      req_valid = '0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'h77; rsp_ready = 4'b1000;
      for (int k = 0; k < 2; k++) begin
         eval();
         check("bp_mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
         check("bp_rsp_valid", 64'(rsp_valid), 64'b0010);
         tick();
      end
      rsp_ready = 4'b1010;
      cycle();
      eval();
      check("bp_rsp3", 64'(rsp_valid), 64'b1000);
      check("bp_rsp3_type", 64'(rsp_type), 64'(T_STORE));
      tick();
      mem_rsp_valid = 1'b0;

      // Randomized run
      do_reset("rand_reset");
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               set_req(i, 1'($urandom_range(0, 1)), {8'($urandom), 32'($urandom)},
                       3'($urandom_range(0, 3)), {32'($urandom), 32'($urandom)});
         mem_req_ready = ($urandom_range(0, 3) != 0);
         mem_rsp_valid = (q.size() != 0) && ($urandom_range(0, 1) == 1);
         mem_rsp_data  = {32'($urandom), 32'($urandom)};
         rsp_ready     = N'($urandom);
         cycle();
         if (hs_idx >= 0) req_valid[hs_idx] = 1'b0;
      end

      // Spurious response, then reset mid-flight
      do_reset("spur_reset");
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD;
      eval();
      check("spur_drop_ready", 64'(mem_rsp_ready), 64'd1);
      check("spur_rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
      mem_rsp_valid = 1'b0;
      check("spur_err", 64'(err), 64'd1);
      set_req(0, T_STORE, 40'h42, 3'd2, 64'h42);
      mem_req_ready = 1'b1;
      cycle();
      cycle();
      check("spur_err_sticky", 64'(err), 64'd1);
      check("spur_busy", 64'(busy), 64'd1);
      do_reset("midflight");
      mem_rsp_valid = 1'b1;
      cycle();
      mem_rsp_valid = 1'b0;
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
